// File: rtl/div_pkg.sv
// Shared definitions for the shared-divider front end: divider opcodes and
// the sequencing FSM encoding.
package div_pkg;

    localparam logic [1:0] DIV_OPC_DIVU = 2'b00;
    localparam logic [1:0] DIV_OPC_DIV  = 2'b01;
    localparam logic [1:0] DIV_OPC_REMU = 2'b10;
    localparam logic [1:0] DIV_OPC_REM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } div_state_e;

    function automatic logic opc_is_signed(input logic [1:0] opc);
        return (opc == DIV_OPC_DIV) || (opc == DIV_OPC_REM);
    endfunction

    function automatic logic opc_is_rem(input logic [1:0] opc);
        return (opc == DIV_OPC_REMU) || (opc == DIV_OPC_REM);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr,
// searching cyclically, wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        // Walk from the farthest offset back to ptr so the nearest request
        // overwrites the rest and wins.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[IDX_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one serial divider among NUM_REQ requesters: round-robin grant,
// operand capture, divider load/flush sequencing and a tagged response.
module div_share_arbiter
    import div_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_op1,
    input  logic [NUM_REQ*WIDTH-1:0]     req_op2,
    input  logic [NUM_REQ*2-1:0]         req_opc,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    output logic [WIDTH-1:0]             div_input1,
    output logic [WIDTH-1:0]             div_input2,
    output logic [1:0]                   div_operation,
    output logic                         div_input_valid,
    output logic                         div_flush,
    input  logic                         div_ready,
    input  logic                         div_output_valid,
    input  logic [WIDTH-1:0]             div_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH-1:0]             rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic                         busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    div_state_e          state;
    div_state_e          state_next;

    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_valid;
    logic                take;
    logic                catch_result;

    logic [WIDTH-1:0]    op1_q;
    logic [WIDTH-1:0]    op2_q;
    logic [1:0]          opc_q;
    logic [TAG_W-1:0]    tag_q;
    logic [ID_W-1:0]     id_q;
    logic [WIDTH-1:0]    rsp_data_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [TAG_W-1:0]    rsp_tag_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        req_ready       = '0;
        take            = 1'b0;
        catch_result    = 1'b0;
        div_input_valid = 1'b0;
        rsp_valid       = 1'b0;
        div_flush       = flush;

        unique case (state)
            ST_IDLE: begin
                if (div_ready && !flush && grant_valid) begin
                    req_ready  = grant;
                    take       = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A flush on the issue cycle must not start the divider.
                div_input_valid = !flush;
                state_next      = ST_BUSY;
            end
            ST_BUSY: begin
                if (div_output_valid && !flush) begin
                    catch_result = 1'b1;
                    state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            opc_q  <= '0;
            tag_q  <= '0;
            id_q   <= '0;
        end else if (take) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            op1_q  <= req_op1[grant_idx*WIDTH +: WIDTH];
            op2_q  <= req_op2[grant_idx*WIDTH +: WIDTH];
            opc_q  <= req_opc[grant_idx*2 +: 2];
            tag_q  <= req_tag[grant_idx*TAG_W +: TAG_W];
            id_q   <= grant_idx;
        end
    end

    // The divider pulses its result for one cycle only, so it is caught here
    // and held for however long the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_tag_q  <= '0;
        end else if (catch_result) begin
            rsp_data_q <= div_result;
            rsp_id_q   <= id_q;
            rsp_tag_q  <= tag_q;
        end
    end

    assign div_input1    = op1_q;
    assign div_input2    = op2_q;
    assign div_operation = opc_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_tag       = rsp_tag_q;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a fixed-latency divider model.
module tb_div_share_arbiter;
    import div_pkg::*;

    localparam int W       = 64;
    localparam int N       = 4;
    localparam int TW      = 6;
    localparam int DIV_LAT = 5;   // divider input_valid cycle -> result pulse cycle

    logic              clk;
    logic              rst;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_op1;
    logic [N*W-1:0]    req_op2;
    logic [N*2-1:0]    req_opc;
    logic [N*TW-1:0]   req_tag;
    logic [W-1:0]      div_input1;
    logic [W-1:0]      div_input2;
    logic [1:0]        div_operation;
    logic              div_input_valid;
    logic              div_flush;
    logic              div_ready;
    logic              div_output_valid;
    logic [W-1:0]      div_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [1:0]        rsp_id;
    logic [TW-1:0]     rsp_tag;
    logic              busy;

    int checks = 0;
    int errors = 0;

    div_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .TAG_W(TW)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op1          (req_op1),
        .req_op2          (req_op2),
        .req_opc          (req_opc),
        .req_tag          (req_tag),
        .div_input1       (div_input1),
        .div_input2       (div_input2),
        .div_operation    (div_operation),
        .div_input_valid  (div_input_valid),
        .div_flush        (div_flush),
        .div_ready        (div_ready),
        .div_output_valid (div_output_valid),
        .div_result       (div_result),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_id           (rsp_id),
        .rsp_tag          (rsp_tag),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Divider model with RISC-V M-extension corner-case semantics.
    function automatic logic [63:0] ref_div(input logic [1:0] opc, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = a;
        sb = b;
        case (opc)
            DIV_OPC_DIVU: return (b == 0) ? '1 : a / b;
            DIV_OPC_REMU: return (b == 0) ? a : a % b;
            DIV_OPC_DIV: begin
                if (b == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) return a;
                return sa / sb;
            end
            default: begin
                if (b == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && sb == -64'sd1) return '0;
                return sa % sb;
            end
        endcase
    endfunction

    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_res;

    assign div_ready = !m_busy && !div_output_valid;

    always @(posedge clk) begin
        if (rst || div_flush) begin
            m_busy           <= 1'b0;
            m_cnt            <= 0;
            div_output_valid <= 1'b0;
            if (rst) div_result <= '0;
        end else begin
            div_output_valid <= 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy           <= 1'b0;
                    div_output_valid <= 1'b1;
                    div_result       <= m_res;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (div_input_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= DIV_LAT - 2;
                m_res  <= ref_div(div_operation, div_input1, div_input2);
            end
        end
    end

    // Result pulses are only legal while the block waits in BUSY.
    always @(negedge clk) begin
        if (!rst && div_output_valid) begin
            check("ovalid_in_busy", 64'(dut.state == ST_BUSY), 64'd1);
        end
    end

    task automatic set_req(input int id, input logic [1:0] opc, input logic [63:0] a,
                           input logic [63:0] b, input logic [TW-1:0] tag);
        req_op1[id*W +: W]   = a;
        req_op2[id*W +: W]   = b;
        req_opc[id*2 +: 2]   = opc;
        req_tag[id*TW +: TW] = tag;
    endtask

    task automatic wait_grant(input string tag);
        int waited;
        waited = 0;
        while (req_ready == '0 && waited < 30) begin
            @(negedge clk); #1;
            waited++;
        end
        check({tag, "_grant_wait"}, 64'(waited), 64'd0);
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk); #1;
            lat++;
        end
        check({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
    endtask

    // One full transaction from a lone requester; starts and ends just after a negedge.
    task automatic run_one(input string tag, input int id, input logic [1:0] opc,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [TW-1:0] utag, input logic [63:0] exp);
        int lat;
        set_req(id, opc, a, b, utag);
        req_valid = N'(1) << id;
        rsp_ready = 1'b1;
        #1;
        wait_grant(tag);
        check({tag, "_grant"}, 64'(req_ready), 64'(N'(1) << id));
        @(negedge clk); #1;
        req_valid = '0;
        check({tag, "_issue_valid"}, 64'(div_input_valid), 64'd1);
        check({tag, "_issue_op1"}, div_input1, a);
        check({tag, "_issue_op2"}, div_input2, b);
        check({tag, "_issue_opc"}, 64'(div_operation), 64'(opc));
        @(negedge clk); #1;
        check({tag, "_issue_once"}, 64'(div_input_valid), 64'd0);
        wait_rsp(tag, lat);
        check({tag, "_latency"}, 64'(lat + 2), 64'(DIV_LAT + 2));
        check({tag, "_data"}, rsp_data, exp);
        check({tag, "_id"}, 64'(rsp_id), 64'(id));
        check({tag, "_tag"}, 64'(rsp_tag), 64'(utag));
        @(negedge clk); #1;
        check({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        int seen;
        logic [63:0] held;
        int rr_order [5];
        logic [63:0] rr_exp [4];
        rr_order = '{0, 1, 2, 3, 0};
        rr_exp   = '{64'd10, 64'd10, 64'd10, 64'd11};

        rst = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_op1 = '0; req_op2 = '0; req_opc = '0; req_tag = '0;
        @(negedge clk);
        do_reset();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_div_in_valid", 64'(div_input_valid), 64'd0);
        check("rst_div_flush", 64'(div_flush), 64'd0);
        check("rst_div_input1", div_input1, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);

        run_one("divu", 0, DIV_OPC_DIVU, 64'd100, 64'd7, 6'd5, 64'd14);
        run_one("rem_neg", 2, DIV_OPC_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd9, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("divu_z", 1, DIV_OPC_DIVU, 64'd123, 64'd0, 6'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("remu_z", 1, DIV_OPC_REMU, 64'd123, 64'd0, 6'd2, 64'd123);

        // Response back-pressure while another requester waits.
        set_req(0, DIV_OPC_DIVU, 64'd50, 64'd5, 6'd3);
        set_req(3, DIV_OPC_DIVU, 64'd8, 64'd2, 6'd4);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        wait_grant("stall");
        check("stall_grant", 64'(req_ready), 64'h1);
        @(negedge clk); #1;
        req_valid = 4'b1000;
        wait_rsp("stall", lat);
        held = rsp_data;
        check("stall_data", held, 64'd10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_valid_held", 64'(rsp_valid), 64'd1);
            check("stall_data_held", rsp_data, held);
            check("stall_no_grant", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("stall_next_grant", 64'(req_ready), 64'b1000);
        @(negedge clk); #1;
        req_valid = '0;
        wait_rsp("stall_r3", lat);
        check("stall_r3_data", rsp_data, 64'd4);
        check("stall_r3_id", 64'(rsp_id), 64'd3);
        @(negedge clk); #1;

        // Flush while the divider is busy: no response may appear.
        set_req(2, DIV_OPC_DIVU, 64'd77, 64'd7, 6'd7);
        req_valid = 4'b0100;
        #1;
        wait_grant("flush");
        @(negedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        flush = 1'b1;
        #1;
        check("flush_div_flush", 64'(div_flush), 64'd1);
        @(negedge clk); #1;
        flush = 1'b0;
        check("flush_idle", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("flush_no_rsp", 64'(seen), 64'd0);

        // Flush in IDLE blocks the grant that cycle.
        set_req(1, DIV_OPC_DIVU, 64'd6, 64'd2, 6'd8);
        req_valid = 4'b0010;
        flush = 1'b1;
        #1;
        check("flush_idle_no_grant", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        flush = 1'b0;
        req_valid = '0;
        check("flush_idle_stays", 64'(busy), 64'd0);

        run_one("after_flush", 3, DIV_OPC_DIVU, 64'd9, 64'd3, 6'd11, 64'd3);

        // Reset mid-operation drops the request silently.
        set_req(0, DIV_OPC_DIVU, 64'd40, 64'd4, 6'd12);
        req_valid = 4'b0001;
        #1;
        wait_grant("rst_mid");
        @(negedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        do_reset();
        check("rst_mid_idle", 64'(busy), 64'd0);
        check("rst_mid_op1", div_input1, 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("rst_mid_no_rsp", 64'(seen), 64'd0);

        // Round-robin with all requesters active from rr_ptr = 0.
        for (int i = 0; i < N; i++) begin
            set_req(i, DIV_OPC_DIVU, 64'(30 + i), 64'd3, TW'(10 + i));
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_grant("rr");
            check("rr_grant", 64'(req_ready), 64'(N'(1) << rr_order[k]));
            @(negedge clk); #1;
            check("rr_no_grant_issue", 64'(req_ready), 64'd0);
            wait_rsp("rr", lat);
            check("rr_id", 64'(rsp_id), 64'(rr_order[k]));
            check("rr_data", rsp_data, rr_exp[rr_order[k]]);
            check("rr_tag", 64'(rsp_tag), 64'(10 + rr_order[k]));
            @(negedge clk); #1;
        end
        req_valid = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one serialdiv integer divider among NUM_REQ requesters, e.g. the ALU lanes of an SM sub-partition.
- Arbitrates requests round-robin and registers the winner's operands.
- Sequences the divider's load/flush handshake and catches its single-cycle result pulse.
- Returns the result on a valid/ready response channel tagged with requester id and user tag.

Parameters:
- WIDTH, 64, operand/result width; must match the attached divider.
- NUM_REQ, 4, number of requesters (≥2).
- TAG_W, 6, user tag width carried with each request.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  abort in-flight op and drop pending response
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_op1  in  NUM_REQ*WIDTH  dividends, packed, requester i at [i*WIDTH +: WIDTH]
- req_op2  in  NUM_REQ*WIDTH  divisors, packed
- req_opc  in  NUM_REQ*2  operation per requester: 00 DIVU, 01 DIV, 10 REMU, 11 REM
- req_tag  in  NUM_REQ*TAG_W  user tags
- div_input1  out  WIDTH  registered op1 to divider
- div_input2  out  WIDTH  registered op2 to divider
- div_operation  out  2  registered opcode
- div_input_valid  out  1  load strobe
- div_flush  out  1  abort strobe to divider
- div_ready  in  1  divider idle
- div_output_valid  in  1  result pulse (exactly one cycle)
- div_result  in  WIDTH  divider result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  WIDTH  quotient/remainder
- rsp_id  out  $clog2(NUM_REQ)  requester index
- rsp_tag  out  TAG_W  echoed tag
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE, rr_ptr 0. All outputs 0 (req_ready, div_input_valid, div_flush, rsp_valid, rsp_data, rsp_id, rsp_tag, div_input1/2, div_operation); busy 0.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Arbitration happens only when div_ready=1, flush=0 and any req_valid=1.
  - Winner is the first set req_valid at or after rr_ptr, cyclic search.
  - req_ready[winner]=1 combinationally in the same cycle. This is the request handshake.
  - Winner's op1/op2/opc/tag/id are captured into registers; rr_ptr <= (winner+1) mod NUM_REQ; next state ISSUE.
  - req_ready is never asserted in any other state.
- ISSUE: div_input_valid=1 for exactly one cycle, with registered operands on div_input*; next state BUSY.
- BUSY:
  - Wait for div_output_valid.
  - On the pulse: rsp_data <= div_result, rsp_id/rsp_tag from registers, next state RESP.
- RESP:
  - rsp_valid=1; rsp_data/id/tag are held stable until rsp_ready.
  - rsp_valid & rsp_ready -> IDLE. New arbitration starts the following cycle.
- Latency: request accept to rsp_valid = 2 + divider latency cycles. Throughput is one op in flight; no pipelining.
- div_output_valid outside BUSY is ignored. This is a protocol error; the bench flags it as an assertion.
- flush, any state:
  - div_flush=1 the same cycle; next state IDLE; rsp_valid deasserts next cycle.
  - rr_ptr unchanged; the captured request is discarded with no response.
  - flush in IDLE blocks the grant that cycle.
- rst mid-operation: returns to IDLE with no response. The divider shares rst, so no flush is needed.
- Single-requester case: repeated requests from the same id are granted back-to-back; the pointer wrap gives no penalty.
- Arithmetic semantics (div-by-zero, overflow) are the divider's; this block passes data through unchanged.

Decomposition:
- Shared package div_pkg: opcode localparams DIV_OPC_DIVU=2'b00, DIV_OPC_DIV=2'b01, DIV_OPC_REMU=2'b10, DIV_OPC_REM=2'b11; FSM state encoding.
- One sub-module, rr_arbiter (NUM_REQ): req vector and pointer in, one-hot grant plus encoded index out; combinational only.
- The divider is instantiated by the parent, not inside this block.

Test Plan:
- Req0 DIVU op1=100, op2=7, tag=5 -> one req_ready[0] pulse; one div_input_valid pulse; rsp_data=14, rsp_id=0, rsp_tag=5.
- Req2 REM op1=-7 (0xFFFF_FFFF_FFFF_FFF9), op2=2 -> rsp_data=0xFFFF_FFFF_FFFF_FFFF (-1), rsp_id=2.
- Req1 DIVU 123/0 -> rsp_data all ones. Then REMU 123/0 -> rsp_data=123.
- All four req_valid held high with rr_ptr=0, rsp_ready=1 -> grant order 0,1,2,3,0; each id responds once per round.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and data stable; no req_ready asserted; next grant on the cycle after the handshake.
- flush asserted during BUSY -> div_flush pulse; no rsp_valid. A following req3 DIVU 9/3 completes with rsp_data=3.
